// File: rtl/systolic_pkg.sv
// ============================================================================
// Module : systolic_pkg
// Shared FSM state encoding and sizing helpers for the systolic operand feeder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      FEED  = 2'd2,
      DRAIN = 2'd3
   } feeder_state_t;

   // Number of skewed feed steps for an n x n array.
   function automatic int feed_steps(input int n);
      return 3 * n - 2;
   endfunction

   function automatic int step_width(input int n);
      return $clog2(3 * n - 1);
   endfunction

   // True when element 'elem' of lane 'lane' is on the wavefront at 'step'.
   function automatic logic skew_hit(input int step, input int lane, input int elem);
      return (step == lane + elem);
   endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_feed_bank.sv
// ============================================================================
// Module : systolic_feed_bank
// NxN operand store with a row write port and a skewed read-out for step k.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_feed_bank
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 4,
   parameter bit COL_SKEW   = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [$clog2(N)-1:0]          wr_row,
   input  logic [N*DATA_WIDTH-1:0]       wr_data,
   input  logic [$clog2(3*N-1)-1:0]      rd_step,
   output logic [N*DATA_WIDTH-1:0]       lanes
);

   localparam int ROW_W = $clog2(N);

   logic [N*DATA_WIDTH-1:0] mem_q [N];
   logic [N*DATA_WIDTH-1:0] mem_d [N];

   // Rows beyond N-1 match no entry, so such writes are simply dropped.
   always_comb begin
      for (int r = 0; r < N; r++) begin
         mem_d[r] = mem_q[r];
         if (wr_en && (wr_row == ROW_W'(r))) begin
            mem_d[r] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < N; r++) begin
            mem_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < N; r++) begin
            mem_q[r] <= mem_d[r];
         end
      end
   end

   generate
      if (COL_SKEW == 1'b0) begin : g_row_skew
         // Lane i carries A[i][k-i].
         always_comb begin
            lanes = '0;
            for (int i = 0; i < N; i++) begin
               for (int c = 0; c < N; c++) begin
                  if (skew_hit(int'(rd_step), i, c)) begin
                     lanes[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][c*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
         end
      end else begin : g_col_skew
         // Lane j carries B[k-j][j].
         always_comb begin
            lanes = '0;
            for (int j = 0; j < N; j++) begin
               for (int r = 0; r < N; r++) begin
                  if (skew_hit(int'(rd_step), j, r)) begin
                     lanes[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[r][j*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
// Module : systolic_feeder
// Stores A/B and streams them skewed into an NxN systolic MAC array.
// Optional: FEEDER_DOUBLE_BUF_EN adds shadow banks that load during a run.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load_valid,
   output logic                          load_ready,
   input  logic                          load_sel,
   input  logic [$clog2(N)-1:0]          load_row,
   input  logic [N*DATA_WIDTH-1:0]       load_data,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          array_clear,
   output logic                          feed_valid,
   output logic [N*DATA_WIDTH-1:0]       row_operands_out,
   output logic [N*DATA_WIDTH-1:0]       col_operands_out
);

   localparam int STEP_W    = step_width(N);
   localparam int LAST_STEP = feed_steps(N) - 1;
   localparam int LANE_W    = N * DATA_WIDTH;

   feeder_state_t      state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic               done_q, done_d;
   logic [LANE_W-1:0]  row_q, row_d;
   logic [LANE_W-1:0]  col_q, col_d;
   logic [LANE_W-1:0]  a_lanes, b_lanes;
   logic               load_acc;
   logic               start_acc;

   assign start_acc = start && (state_q == IDLE);
   assign load_acc  = load_valid && load_ready;

`ifdef FEEDER_DOUBLE_BUF_EN
   logic              bank_sel_q, bank_sel_d;
   logic [LANE_W-1:0] a0_lanes, a1_lanes, b0_lanes, b1_lanes;

   assign load_ready = 1'b1;
   assign bank_sel_d = start_acc ? ~bank_sel_q : bank_sel_q;

   // Loads target the inactive bank; start makes it the active one.
   systolic_feed_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .COL_SKEW(1'b0)) u_a_bank0 (
      .clk(clk), .reset(reset), .wr_en(load_acc && !load_sel && bank_sel_q),
      .wr_row(load_row), .wr_data(load_data), .rd_step(step_d), .lanes(a0_lanes));
   systolic_feed_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .COL_SKEW(1'b0)) u_a_bank1 (
      .clk(clk), .reset(reset), .wr_en(load_acc && !load_sel && !bank_sel_q),
      .wr_row(load_row), .wr_data(load_data), .rd_step(step_d), .lanes(a1_lanes));
   systolic_feed_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .COL_SKEW(1'b1)) u_b_bank0 (
      .clk(clk), .reset(reset), .wr_en(load_acc && load_sel && bank_sel_q),
      .wr_row(load_row), .wr_data(load_data), .rd_step(step_d), .lanes(b0_lanes));
   systolic_feed_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .COL_SKEW(1'b1)) u_b_bank1 (
      .clk(clk), .reset(reset), .wr_en(load_acc && load_sel && !bank_sel_q),
      .wr_row(load_row), .wr_data(load_data), .rd_step(step_d), .lanes(b1_lanes));

   assign a_lanes = bank_sel_q ? a1_lanes : a0_lanes;
   assign b_lanes = bank_sel_q ? b1_lanes : b0_lanes;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank_sel_q <= 1'b0;
      end else begin
         bank_sel_q <= bank_sel_d;
      end
   end
`else
   assign load_ready = (state_q == IDLE);

   systolic_feed_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .COL_SKEW(1'b0)) u_a_bank (
      .clk(clk), .reset(reset), .wr_en(load_acc && !load_sel),
      .wr_row(load_row), .wr_data(load_data), .rd_step(step_d), .lanes(a_lanes));
   systolic_feed_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .COL_SKEW(1'b1)) u_b_bank (
      .clk(clk), .reset(reset), .wr_en(load_acc && load_sel),
      .wr_row(load_row), .wr_data(load_data), .rd_step(step_d), .lanes(b_lanes));
`endif

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_acc) begin
               state_d = CLEAR;
               step_d  = '0;
            end
         end
         CLEAR: begin
            state_d = FEED;
            step_d  = '0;
         end
         FEED: begin
            if (step_q == STEP_W'(LAST_STEP)) begin
               state_d = DRAIN;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         DRAIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Lanes are captured one cycle ahead so the outputs stay registered.
      row_d = (state_d == FEED) ? a_lanes : '0;
      col_d = (state_d == FEED) ? b_lanes : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         step_q  <= '0;
         done_q  <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         done_q  <= done_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   assign busy             = (state_q != IDLE);
   assign done             = done_q;
   assign array_clear      = (state_q == CLEAR);
   assign feed_valid       = (state_q == FEED);
   assign row_operands_out = row_q;
   assign col_operands_out = col_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ============================================================================
// Module : tb_systolic_feeder
// Directed self-checking bench for systolic_feeder (N=4, 8-bit, single bank).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_systolic_feeder;

   localparam int DW    = 8;
   localparam int N     = 4;
   localparam int STEPS = 3 * N - 2;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            load_valid = 1'b0;
   logic            load_ready;
   logic            load_sel = 1'b0;
   logic [1:0]      load_row = '0;
   logic [31:0]     load_data = '0;
   logic            start = 1'b0;
   logic            busy, done, array_clear, feed_valid;
   logic [31:0]     row_operands_out, col_operands_out;

   int              checks = 0;
   int              errors = 0;
   logic [7:0]      am [N][N];
   logic [7:0]      bm [N][N];
   logic [31:0]     cap_row [STEPS];
   logic [31:0]     cap_col [STEPS];
   int              clears, dones;

   systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_sel(load_sel), .load_row(load_row), .load_data(load_data), .start(start),
      .busy(busy), .done(done), .array_clear(array_clear), .feed_valid(feed_valid),
      .row_operands_out(row_operands_out), .col_operands_out(col_operands_out));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_row(input int k);
      logic [31:0] v = '0;
      for (int i = 0; i < N; i++)
         if (k - i >= 0 && k - i < N) v[i*DW +: DW] = am[i][k-i];
      return v;
   endfunction

   function automatic logic [31:0] exp_col(input int k);
      logic [31:0] v = '0;
      for (int j = 0; j < N; j++)
         if (k - j >= 0 && k - j < N) v[j*DW +: DW] = bm[k-j][j];
      return v;
   endfunction

   task automatic load(input logic sel, input int row, input logic [31:0] data);
      load_sel   = sel;
      load_row   = 2'(row);
      load_data  = data;
      load_valid = 1'b1;
      check("load_ready_idle", {31'd0, load_ready}, 32'd1);
      tick();
      load_valid = 1'b0;
      for (int c = 0; c < N; c++) begin
         if (sel) bm[row][c] = data[c*DW +: DW];
         else     am[row][c] = data[c*DW +: DW];
      end
   endtask

   // One complete run; optional start retrigger and load attempt during FEED.
   task automatic run(input int restart_k, input bit load_in_feed);
      clears = 0;
      dones  = 0;
      start  = 1'b1;
      tick();
      start      = 1'b0;
      load_valid = 1'b0;
      clears += int'(array_clear);
      check("clear_state", {28'd0, busy, array_clear, feed_valid, load_ready}, 32'b1100);
      check("clear_lanes", row_operands_out | col_operands_out, 32'd0);
      for (int k = 0; k < STEPS; k++) begin
         tick();
         start = (k == restart_k);
         clears += int'(array_clear);
         dones  += int'(done);
         cap_row[k] = row_operands_out;
         cap_col[k] = col_operands_out;
         check($sformatf("feed_valid_k%0d", k), {31'd0, feed_valid}, 32'd1);
         check($sformatf("row_k%0d", k), row_operands_out, exp_row(k));
         check($sformatf("col_k%0d", k), col_operands_out, exp_col(k));
         if (load_in_feed && k == 2) begin
            check("load_ready_feed", {31'd0, load_ready}, 32'd0);
            load_sel   = 1'b0;
            load_row   = 2'd0;
            load_data  = 32'hFFFF_FFFF;
            load_valid = 1'b1;
         end else begin
            load_valid = 1'b0;
         end
      end
      tick();
      start      = 1'b0;
      load_valid = 1'b0;
      clears += int'(array_clear);
      dones  += int'(done);
      check("drain_state", {29'd0, busy, feed_valid, done}, 32'b100);
      check("drain_lanes", row_operands_out | col_operands_out, 32'd0);
      tick();
      clears += int'(array_clear);
      dones  += int'(done);
      check("done_cycle", {29'd0, busy, done, load_ready}, 32'b011);
      for (int t = 0; t < 3; t++) begin
         tick();
         clears += int'(array_clear);
         dones  += int'(done);
         check("idle_after_done", {30'd0, busy, done}, 32'd0);
      end
      check("clear_pulses", 32'(clears), 32'd1);
      check("done_pulses", 32'(dones), 32'd1);
   endtask

   initial begin
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            am[r][c] = '0;
            bm[r][c] = '0;
         end
      repeat (2) tick();
      check("rst_outputs", {26'd0, busy, done, array_clear, feed_valid, load_ready, 1'b0}, 32'b000010);
      check("rst_lanes", row_operands_out | col_operands_out, 32'd0);
      reset = 1'b1;
      tick();

      // A rows 1..16, B identity
      load(1'b0, 0, 32'h04030201);
      load(1'b0, 1, 32'h08070605);
      load(1'b0, 2, 32'h0C0B0A09);
      load(1'b0, 3, 32'h100F0E0D);
      load(1'b1, 0, 32'h00000001);
      load(1'b1, 1, 32'h00000100);
      load(1'b1, 2, 32'h00010000);
      load(1'b1, 3, 32'h01000000);
      run(-1, 1'b0);
      check("a_k0", cap_row[0], 32'h00000001);
      check("a_k1", cap_row[1], 32'h00000502);
      check("a_k6", cap_row[6], 32'h10000000);
      check("b_k0", cap_col[0], 32'h00000001);
      check("b_k1", cap_col[1], 32'h00000000);
      check("b_k2", cap_col[2], 32'h00000100);
      check("b_k4", cap_col[4], 32'h00010000);
      check("b_k6", cap_col[6], 32'h01000000);
      check("b_k7", cap_col[7], 32'h00000000);

      // load and start in the same IDLE cycle
      load_sel   = 1'b0;
      load_row   = 2'd0;
      load_data  = 32'h09090909;
      load_valid = 1'b1;
      for (int c = 0; c < N; c++) am[0][c] = 8'd9;
      run(3, 1'b0);
      check("a_k0_same_cycle", cap_row[0], 32'h00000009);

      // load attempted during FEED must not land
      run(-1, 1'b1);
      run(-1, 1'b0);
      check("a_k0_after_feed_load", cap_row[0], 32'h00000009);

      // asynchronous reset mid-FEED
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("feed_before_rst", {31'd0, feed_valid}, 32'd1);
      reset = 1'b0;
      tick();
      check("rst_mid_state", {29'd0, busy, feed_valid, load_ready}, 32'b001);
      check("rst_mid_lanes", row_operands_out | col_operands_out, 32'd0);
      reset = 1'b1;
      tick();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            am[r][c] = '0;
            bm[r][c] = '0;
         end
      run(-1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
